// File: rtl/rv32_pkg.sv
// Shared RV32I memory-stage constants: funct3 encodings, writeback selects,
// exception codes and load/store FSM states.
package rv32_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;
  localparam logic [1:0] WB_IMM = 2'b11;

  localparam logic [1:0] EXC_NONE     = 2'b00;
  localparam logic [1:0] EXC_MISALIGN = 2'b01;
  localparam logic [1:0] EXC_TIMEOUT  = 2'b10;
  localparam logic [1:0] EXC_ILLEGAL  = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: store byte-enables and data replication,
// alignment/funct3 checks, and load lane extraction with sign/zero extension.
module lsu_align import rv32_pkg::*; (
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  lane_i,
  input  logic        is_load_i,
  input  logic        is_store_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic        misalign_o,
  output logic        illegal_o,
  input  logic [2:0]  ld_funct3_i,
  input  logic [1:0]  ld_lane_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] ldata_o
);

  logic [31:0] shifted;

  always_comb begin
    be_o       = 4'b1111;
    wdata_o    = wdata_i;
    misalign_o = 1'b0;
    illegal_o  = 1'b0;
    if (is_load_i)
      illegal_o = (funct3_i == 3'b011) || (funct3_i[2:1] == 2'b11);
    else if (is_store_i)
      illegal_o = !(funct3_i inside {F3_SB, F3_SH, F3_SW});
    case (funct3_i[1:0])
      2'b01:   misalign_o = lane_i[0];
      2'b10:   misalign_o = |lane_i;
      default: misalign_o = 1'b0;
    endcase
    if (is_store_i) begin
      case (funct3_i)
        F3_SB: begin
          be_o    = 4'b0001 << lane_i;
          wdata_o = {4{wdata_i[7:0]}};
        end
        F3_SH: begin
          be_o    = 4'b0011 << lane_i;
          wdata_o = {2{wdata_i[15:0]}};
        end
        default: be_o = 4'b1111;
      endcase
    end
  end

  // Loads shift the addressed lane down to bit 0, then extend by size/sign.
  always_comb begin
    shifted = rdata_i >> {ld_lane_i, 3'b000};
    case (ld_funct3_i)
      F3_LB:   ldata_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_LH:   ldata_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_LBU:  ldata_o = {24'h0, shifted[7:0]};
      F3_LHU:  ldata_o = {16'h0, shifted[15:0]};
      default: ldata_o = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I MEM stage: data-memory req/ack handshake with timeout abort, load
// alignment, store byte-enables, and registered MEM/WB writeback fields.
module load_store_unit import rv32_pkg::*; #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  input  logic [31:0] ex_imm,
  input  logic [31:0] ex_pc_plus4,
  input  logic [4:0]  ex_rd,
  input  logic        ex_reg_write,
  input  logic [1:0]  ex_wb_sel,
  output logic        mem_stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic        wb_reg_write,
  output logic [1:0]  wb_sel,
  output logic [31:0] wb_alu,
  output logic [31:0] wb_load,
  output logic [31:0] wb_pc_plus4,
  output logic [31:0] wb_imm,
  output logic [1:0]  wb_exc
);

  localparam int unsigned TO_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam int unsigned CNT_W   = (TO_LAST > 0) ? $clog2(TO_LAST + 1) : 1;

  lsu_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       f3_q;
  logic [1:0]       lane_q;
  logic             rw_q;
  logic             req_q, we_q;
  logic [31:0]      addr_q, wdata_q;
  logic [3:0]       be_q;
  logic             wb_valid_q, wb_reg_write_q;
  logic [4:0]       wb_rd_q;
  logic [1:0]       wb_sel_q, wb_exc_q;
  logic [31:0]      wb_alu_q, wb_load_q, wb_pc4_q, wb_imm_q;

  logic        is_store, mem_access, fault, mem_op, misalign, illegal, timeout;
  logic [3:0]  be_c;
  logic [31:0] wdata_c, ldata_c;

  lsu_align u_align (
    .funct3_i    (ex_funct3),
    .lane_i      (ex_addr[1:0]),
    .is_load_i   (ex_mem_read),
    .is_store_i  (is_store),
    .wdata_i     (ex_wdata),
    .be_o        (be_c),
    .wdata_o     (wdata_c),
    .misalign_o  (misalign),
    .illegal_o   (illegal),
    .ld_funct3_i (f3_q),
    .ld_lane_i   (lane_q),
    .rdata_i     (dmem_rdata),
    .ldata_o     (ldata_c)
  );

  // A slot flagged as both load and store is treated as a load.
  assign is_store   = ex_mem_write & ~ex_mem_read;
  assign mem_access = ex_valid & (ex_mem_read | ex_mem_write);
  assign fault      = mem_access & (misalign | illegal);
  assign mem_op     = mem_access & ~fault;
  assign timeout    = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TO_LAST));
  assign mem_stall  = ~rst & (((state_q == ST_IDLE) & mem_op) |
                              ((state_q == ST_REQ) & ~dmem_ack));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      f3_q           <= '0;
      lane_q         <= '0;
      rw_q           <= 1'b0;
      req_q          <= 1'b0;
      we_q           <= 1'b0;
      addr_q         <= '0;
      be_q           <= '0;
      wdata_q        <= '0;
      wb_valid_q     <= 1'b0;
      wb_reg_write_q <= 1'b0;
      wb_rd_q        <= '0;
      wb_sel_q       <= '0;
      wb_exc_q       <= '0;
      wb_alu_q       <= '0;
      wb_load_q      <= '0;
      wb_pc4_q       <= '0;
      wb_imm_q       <= '0;
    end else begin
      wb_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // Pass-through fields are captured now; a memory op only raises
          // wb_valid once the access completes.
          if (ex_valid) begin
            wb_valid_q     <= ~mem_op;
            wb_rd_q        <= ex_rd;
            wb_sel_q       <= ex_wb_sel;
            wb_alu_q       <= ex_addr;
            wb_pc4_q       <= ex_pc_plus4;
            wb_imm_q       <= ex_imm;
            wb_load_q      <= '0;
            wb_reg_write_q <= ex_reg_write & ~mem_access;
            wb_exc_q       <= !mem_access ? EXC_NONE :
                              illegal     ? EXC_ILLEGAL :
                              misalign    ? EXC_MISALIGN : EXC_NONE;
          end
          if (mem_op) begin
            state_q <= ST_REQ;
            cnt_q   <= '0;
            req_q   <= 1'b1;
            we_q    <= is_store;
            addr_q  <= {ex_addr[31:2], 2'b00};
            be_q    <= be_c;
            wdata_q <= wdata_c;
            f3_q    <= ex_funct3;
            lane_q  <= ex_addr[1:0];
            rw_q    <= ex_reg_write & ex_mem_read;
          end
        end
        ST_REQ: begin
          if (dmem_ack) begin
            wb_valid_q     <= 1'b1;
            wb_load_q      <= we_q ? '0 : ldata_c;
            wb_reg_write_q <= rw_q;
            wb_exc_q       <= EXC_NONE;
            req_q          <= 1'b0;
            state_q        <= ST_IDLE;
          end else if (timeout) begin
            wb_valid_q     <= 1'b1;
            wb_reg_write_q <= 1'b0;
            wb_exc_q       <= EXC_TIMEOUT;
            req_q          <= 1'b0;
            state_q        <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign dmem_req     = req_q;
  assign dmem_we      = we_q;
  assign dmem_addr    = addr_q;
  assign dmem_be      = be_q;
  assign dmem_wdata   = wdata_q;
  assign wb_valid     = wb_valid_q;
  assign wb_rd        = wb_rd_q;
  assign wb_reg_write = wb_reg_write_q;
  assign wb_sel       = wb_sel_q;
  assign wb_alu       = wb_alu_q;
  assign wb_load      = wb_load_q;
  assign wb_pc_plus4  = wb_pc4_q;
  assign wb_imm       = wb_imm_q;
  assign wb_exc       = wb_exc_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: expected writebacks are queued at
// issue time and checked whenever wb_valid is seen.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_mem_read, ex_mem_write, ex_reg_write;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_addr, ex_wdata, ex_imm, ex_pc_plus4;
  logic [4:0]  ex_rd;
  logic [1:0]  ex_wb_sel;
  logic        mem_stall, dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        wb_valid, wb_reg_write;
  logic [4:0]  wb_rd;
  logic [1:0]  wb_sel, wb_exc;
  logic [31:0] wb_alu, wb_load, wb_pc_plus4, wb_imm;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_imm(ex_imm),
    .ex_pc_plus4(ex_pc_plus4), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_wb_sel(ex_wb_sel), .mem_stall(mem_stall), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_sel(wb_sel),
    .wb_alu(wb_alu), .wb_load(wb_load), .wb_pc_plus4(wb_pc_plus4), .wb_imm(wb_imm),
    .wb_exc(wb_exc)
  );

  typedef struct {
    logic [4:0]  rd;
    logic        rw;
    logic [1:0]  sel;
    logic [31:0] alu, ld, pc4, imm;
    logic [1:0]  exc;
    bit          chk_ld;
  } exp_t;

  typedef struct {
    bit          ld;
    logic [2:0]  f3;
    logic [31:0] addr, wdata, rdata;
    int          waits;
    logic [3:0]  be;
    logic [31:0] wd, ldv;
  } op_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst === 1'b0 && wb_valid === 1'b1) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: wb_valid=1 rd=%0d exc=%b, expected no writeback", wb_rd, wb_exc);
      end else begin
        e = sb.pop_front();
        n_checks++;
        if ({wb_rd, wb_reg_write, wb_sel, wb_exc} !== {e.rd, e.rw, e.sel, e.exc}) begin
          n_fail++;
          $display("FAIL sb_ctl: got rd=%0d rw=%b sel=%b exc=%b, expected rd=%0d rw=%b sel=%b exc=%b",
                   wb_rd, wb_reg_write, wb_sel, wb_exc, e.rd, e.rw, e.sel, e.exc);
        end
        n_checks++;
        if ({wb_alu, wb_pc_plus4, wb_imm} !== {e.alu, e.pc4, e.imm}) begin
          n_fail++;
          $display("FAIL sb_pass: got alu=%h pc4=%h imm=%h, expected alu=%h pc4=%h imm=%h",
                   wb_alu, wb_pc_plus4, wb_imm, e.alu, e.pc4, e.imm);
        end
        if (e.chk_ld) begin
          n_checks++;
          if (wb_load !== e.ld) begin
            n_fail++;
            $display("FAIL sb_load: got wb_load=%h, expected %h", wb_load, e.ld);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ex();
    ex_valid     = 1'b0;
    ex_mem_read  = 1'b0;
    ex_mem_write = 1'b0;
    dmem_ack     = 1'b0;
  endtask

  task automatic drive_op(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [4:0] rd, input logic rw, input logic [1:0] sel);
    ex_valid     = 1'b1;
    ex_mem_read  = rd_en;
    ex_mem_write = wr_en;
    ex_funct3    = f3;
    ex_addr      = addr;
    ex_wdata     = wdata;
    ex_rd        = rd;
    ex_reg_write = rw;
    ex_wb_sel    = sel;
    ex_imm       = $urandom;
    ex_pc_plus4  = $urandom;
  endtask

  task automatic push(input logic rw, input logic [1:0] exc, input bit chk, input logic [31:0] ld);
    exp_t e;
    e.rd = ex_rd; e.rw = rw; e.sel = ex_wb_sel; e.alu = ex_addr; e.ld = ld;
    e.pc4 = ex_pc_plus4; e.imm = ex_imm; e.exc = exc; e.chk_ld = chk;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_ex();
    ex_funct3 = '0; ex_addr = '0; ex_wdata = '0; ex_imm = '0; ex_pc_plus4 = '0;
    ex_rd = '0; ex_reg_write = 1'b0; ex_wb_sel = '0; dmem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, mem_stall} !== '0) begin
      n_fail++;
      $display("FAIL reset_dmem: req=%b we=%b addr=%h be=%b wdata=%h stall=%b, expected all 0",
               dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, mem_stall);
    end
    n_checks++;
    if ({wb_valid, wb_rd, wb_reg_write, wb_sel, wb_alu, wb_load, wb_pc_plus4, wb_imm, wb_exc} !== '0) begin
      n_fail++;
      $display("FAIL reset_wb: valid=%b rd=%0d alu=%h load=%h exc=%b, expected all 0",
               wb_valid, wb_rd, wb_alu, wb_load, wb_exc);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_mem_ops();
    op_t t[9];
    t[0] = '{1'b1, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 0, 4'b1111, 32'h0,        32'hDEADBEEF};
    t[1] = '{1'b1, 3'b000, 32'h103, 32'h0,        32'h80FF0000, 3, 4'b1111, 32'h0,        32'hFFFFFF80};
    t[2] = '{1'b1, 3'b100, 32'h103, 32'h0,        32'h80FF0000, 3, 4'b1111, 32'h0,        32'h00000080};
    t[3] = '{1'b1, 3'b001, 32'h102, 32'h0,        32'h80017FFF, 1, 4'b1111, 32'h0,        32'hFFFF8001};
    t[4] = '{1'b1, 3'b101, 32'h100, 32'h0,        32'h8001F00D, 2, 4'b1111, 32'h0,        32'h0000F00D};
    t[5] = '{1'b1, 3'b000, 32'h101, 32'h0,        32'h00007F00, 0, 4'b1111, 32'h0,        32'h0000007F};
    t[6] = '{1'b0, 3'b001, 32'h102, 32'h1234ABCD, 32'h0,        1, 4'b1100, 32'hABCDABCD, 32'h0};
    t[7] = '{1'b0, 3'b000, 32'h101, 32'h000000A5, 32'h0,        0, 4'b0010, 32'hA5A5A5A5, 32'h0};
    t[8] = '{1'b0, 3'b010, 32'h204, 32'hCAFEF00D, 32'h0,        2, 4'b1111, 32'hCAFEF00D, 32'h0};
    for (int i = 0; i < 9; i++) begin
      int stalls;
      stalls = 0;
      tick();
      drive_op(t[i].ld, !t[i].ld, t[i].f3, t[i].addr, t[i].wdata, 5'(i + 1), 1'b1,
               t[i].ld ? 2'b01 : 2'b00);
      push(t[i].ld, 2'b00, t[i].ld, t[i].ldv);
      #1;
      stalls += int'(mem_stall);
      n_checks++;
      if (dmem_req !== 1'b0) begin
        n_fail++;
        $display("FAIL op%0d_issue_req: dmem_req=%b, expected 0", i, dmem_req);
      end
      for (int c = 0; c <= t[i].waits; c++) begin
        tick();
        dmem_ack   = (c == t[i].waits);
        dmem_rdata = dmem_ack ? t[i].rdata : $urandom;
        #1;
        stalls += int'(mem_stall);
        n_checks++;
        if (dmem_req !== 1'b1 || wb_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL op%0d_req_hold c%0d: req=%b wb_valid=%b, expected 1/0", i, c, dmem_req, wb_valid);
        end
        if (c == 0) begin
          n_checks++;
          if ({dmem_we, dmem_addr, dmem_be} !== {!t[i].ld, t[i].addr & ~32'h3, t[i].be}) begin
            n_fail++;
            $display("FAIL op%0d_bus: we=%b addr=%h be=%b, expected we=%b addr=%h be=%b", i,
                     dmem_we, dmem_addr, dmem_be, !t[i].ld, t[i].addr & ~32'h3, t[i].be);
          end
          if (!t[i].ld) begin
            n_checks++;
            if (dmem_wdata !== t[i].wd) begin
              n_fail++;
              $display("FAIL op%0d_wdata: got %h, expected %h", i, dmem_wdata, t[i].wd);
            end
          end
        end
      end
      tick();
      idle_ex();
      #1;
      n_checks++;
      if (dmem_req !== 1'b0 || wb_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL op%0d_complete: req=%b wb_valid=%b, expected 0/1", i, dmem_req, wb_valid);
      end
      n_checks++;
      if (stalls != t[i].waits + 1) begin
        n_fail++;
        $display("FAIL op%0d_stall_cycles: got %0d, expected %0d", i, stalls, t[i].waits + 1);
      end
    end
  endtask

  task automatic test_faults();
    logic [1:0]  rw_sel [8] = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b10, 2'b10, 2'b01, 2'b00};
    logic [2:0]  f3s    [8] = '{3'b010, 3'b001, 3'b001, 3'b010, 3'b011, 3'b110, 3'b100, 3'b010};
    logic [31:0] addrs  [8] = '{32'h101, 32'h103, 32'h101, 32'h102, 32'h100, 32'h100, 32'h100, 32'h101};
    logic [1:0]  excs   [8] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b11, 2'b11, 2'b11, 2'b00};
    for (int i = 0; i < 8; i++) begin
      tick();
      drive_op(rw_sel[i][1], rw_sel[i][0], f3s[i], addrs[i], $urandom, 5'(20 + i), 1'b1, 2'(i));
      push(rw_sel[i] == 2'b00, excs[i], 1'b0, 32'h0);
      #1;
      n_checks++;
      if (mem_stall !== 1'b0) begin
        n_fail++;
        $display("FAIL fault%0d_stall: mem_stall=%b, expected 0", i, mem_stall);
      end
      tick();
      idle_ex();
      #1;
      n_checks++;
      if (dmem_req !== 1'b0 || wb_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL fault%0d_wb: req=%b wb_valid=%b, expected 0/1", i, dmem_req, wb_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) begin
      tick();
      drive_op(1'b0, 1'b0, 3'($urandom), $urandom, $urandom, 5'($urandom), 1'b1, 2'($urandom));
      push(1'b1, 2'b00, 1'b0, 32'h0);
      #1;
      n_checks++;
      if (mem_stall !== 1'b0 || dmem_req !== 1'b0 || (i > 0 && wb_valid !== 1'b1)) begin
        n_fail++;
        $display("FAIL b2b_alu%0d: stall=%b req=%b wb_valid=%b, expected 0/0/%0d", i,
                 mem_stall, dmem_req, wb_valid, i > 0);
      end
    end
    tick();
    drive_op(1'b1, 1'b0, 3'b010, 32'h500, 32'h0, 5'd31, 1'b1, 2'b01);
    push(1'b1, 2'b00, 1'b1, 32'h13579BDF);
    tick();
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h13579BDF;
    #1;
    n_checks++;
    if (mem_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_ack_stall: mem_stall=%b, expected 0", mem_stall);
    end
    tick();
    dmem_ack = 1'b0;
    drive_op(1'b0, 1'b0, 3'b000, 32'h600, 32'h0, 5'd7, 1'b1, 2'b11);
    push(1'b1, 2'b00, 1'b0, 32'h0);
    #1;
    n_checks++;
    if (wb_valid !== 1'b1 || mem_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_load_then_alu: wb_valid=%b stall=%b, expected 1/0", wb_valid, mem_stall);
    end
    tick();
    idle_ex();
    #1;
    n_checks++;
    if (wb_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_alu_after_load: wb_valid=%b, expected 1", wb_valid);
    end
  endtask

  task automatic test_timeout();
    tick();
    drive_op(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 5'd9, 1'b1, 2'b01);
    push(1'b0, 2'b10, 1'b0, 32'h0);
    for (int c = 0; c < 4; c++) begin
      tick();
      dmem_ack = 1'b0;
      #1;
      n_checks++;
      if (dmem_req !== 1'b1 || mem_stall !== 1'b1 || wb_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL timeout_wait c%0d: req=%b stall=%b wb_valid=%b, expected 1/1/0", c,
                 dmem_req, mem_stall, wb_valid);
      end
    end
    tick();
    idle_ex();
    #1;
    n_checks++;
    if (dmem_req !== 1'b0 || mem_stall !== 1'b0 || wb_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_abort: req=%b stall=%b wb_valid=%b, expected 0/0/1", dmem_req, mem_stall, wb_valid);
    end
    tick();
    drive_op(1'b1, 1'b0, 3'b010, 32'h304, 32'h0, 5'd10, 1'b1, 2'b01);
    push(1'b1, 2'b00, 1'b1, 32'h0BADF00D);
    for (int c = 0; c < 4; c++) begin
      tick();
      dmem_ack   = (c == 3);
      dmem_rdata = 32'h0BADF00D;
      #1;
      n_checks++;
      if (dmem_req !== 1'b1) begin
        n_fail++;
        $display("FAIL late_ack_req c%0d: req=%b, expected 1", c, dmem_req);
      end
    end
    tick();
    idle_ex();
    #1;
    n_checks++;
    if (dmem_req !== 1'b0 || wb_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL late_ack_complete: req=%b wb_valid=%b, expected 0/1", dmem_req, wb_valid);
    end
  endtask

  task automatic test_reset_mid_req();
    tick();
    drive_op(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 5'd3, 1'b1, 2'b01);
    tick();
    #1;
    n_checks++;
    if (dmem_req !== 1'b1 || mem_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL midreq_setup: req=%b stall=%b, expected 1/1", dmem_req, mem_stall);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (dmem_req !== 1'b0 || mem_stall !== 1'b0 || wb_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midreq_async_rst: req=%b stall=%b wb_valid=%b, expected 0/0/0",
               dmem_req, mem_stall, wb_valid);
    end
    tick();
    idle_ex();
    @(negedge clk);
    rst = 1'b0;
    tick();
    n_checks++;
    if (dmem_req !== 1'b0 || mem_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL midreq_after_release: req=%b stall=%b, expected 0/0", dmem_req, mem_stall);
    end
    drive_op(1'b0, 1'b0, 3'b000, 32'h44, 32'h0, 5'd4, 1'b1, 2'b00);
    push(1'b1, 2'b00, 1'b0, 32'h0);
    tick();
    idle_ex();
    #1;
    n_checks++;
    if (wb_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL midreq_idle_op: wb_valid=%b, expected 1", wb_valid);
    end
  endtask

  initial begin
    test_reset();
    test_mem_ops();
    test_faults();
    test_back_to_back();
    test_timeout();
    test_reset_mid_req();
    repeat (2) tick();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: %0d writebacks never seen, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
